// File: rtl/sonar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sonar_pkg
// Description : Shared state encoding and timing helpers for the sonar
//               driver / echo emulator pair.
// Revision    : 1.0 - initial release
// ============================================================================
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG_HI = 3'd1,
        ST_BURST   = 3'd2,
        ST_ECHO    = 3'd3,
        ST_HOLDOFF = 3'd4
    } sonar_state_t;

    localparam int SOUND_SPEED_MM_S = 343_210;

    // 10 us minimum trigger width
    function automatic int trig_min_cycles(input int freq);
        return int'(longint'(freq) / 64'd100_000);
    endfunction

    // 38 ms no-object echo width, also the driver's echo timeout
    function automatic int echo_timeout_cycles(input int freq);
        return int'((longint'(freq) * 64'd38) / 64'd1_000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sonar_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sonar_sync_edge
// Description : Two-flop synchronizer with registered rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sonar_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_rise;
    logic r_fall;

    // Pulses line up with the cycle in which r_sync first shows the new level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_rise <= r_meta & ~r_sync;
            r_fall <= ~r_meta & r_sync;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/sonar_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module      : sonar_echo_emulator
// Description : HC-SR04 responder model: validates trig, waits the burst
//               delay, then returns an echo sized by the target distance.
// Revision    : 1.0 - initial release
// ============================================================================
module sonar_echo_emulator
    import sonar_pkg::*;
#(
    parameter int FREQ            = 50_000_000,
    parameter int MIN_TRIG_CYCLES = trig_min_cycles(FREQ),
    parameter int BURST_CYCLES    = FREQ / 5_000,
    parameter int CYCLES_PER_MM   = (FREQ * 2) / SOUND_SPEED_MM_S,
    parameter int MAX_ECHO_CYCLES = echo_timeout_cycles(FREQ),
    parameter int HOLDOFF_CYCLES  = FREQ / 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trig,
    input  logic [15:0] dist_mm,
    input  logic        object_present,
    output logic        echo,
    output logic        busy,
    output logic        trig_err
);

    localparam logic [31:0] c_min     = 32'(MIN_TRIG_CYCLES);
    localparam logic [31:0] c_burst   = 32'(BURST_CYCLES);
    localparam logic [31:0] c_cpm     = 32'(CYCLES_PER_MM);
    localparam logic [31:0] c_max     = 32'(MAX_ECHO_CYCLES);
    localparam logic [31:0] c_holdoff = 32'(HOLDOFF_CYCLES);

    sonar_state_t r_state;
    logic [31:0]  r_cnt;
    logic [31:0]  r_width;
    logic         r_echo;
    logic         r_busy;
    logic         r_trig_err;

    logic         w_rise;
    logic         w_fall;
    logic [31:0]  w_prod;
    logic [31:0]  w_width;

    sonar_sync_edge u_trig_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(trig),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // A zero or out-of-range product reports as "no object"
    assign w_prod  = 32'(dist_mm) * c_cpm;
    assign w_width = (!object_present || (w_prod == 32'd0) || (w_prod > c_max))
                     ? c_max : w_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 32'd0;
            r_width    <= 32'd0;
            r_echo     <= 1'b0;
            r_busy     <= 1'b0;
            r_trig_err <= 1'b0;
        end else begin
            r_trig_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_TRIG_HI;
                        r_cnt   <= 32'd1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_TRIG_HI: begin
                    if (w_fall) begin
                        if (r_cnt >= c_min) begin
                            r_state <= ST_BURST;
                            r_width <= w_width;
                            r_cnt   <= c_burst;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_cnt      <= 32'd0;
                            r_busy     <= 1'b0;
                            r_trig_err <= 1'b1;
                        end
                    end else if (r_cnt < c_min) begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_BURST: begin
                    if (r_cnt == 32'd1) begin
                        r_state <= ST_ECHO;
                        r_echo  <= 1'b1;
                        r_cnt   <= r_width;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                ST_ECHO: begin
                    if (r_cnt == 32'd1) begin
                        r_state <= ST_HOLDOFF;
                        r_echo  <= 1'b0;
                        r_cnt   <= c_holdoff;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                ST_HOLDOFF: begin
                    if (r_cnt == 32'd1) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 32'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 32'd0;
                    r_echo  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign echo     = r_echo;
    assign busy     = r_busy;
    assign trig_err = r_trig_err;

endmodule
`default_nettype wire
